// File: rtl/sys_defs.sv
// Shared machine-wide types: dispatch/complete/retire packets and the ROB entry layout.
package sys_defs;

  localparam int unsigned SYS_ROB_DEPTH = 16;
  localparam int unsigned SYS_ROB_IDX_W = $clog2(SYS_ROB_DEPTH);
  localparam int unsigned SYS_PREG_W    = 6;
  localparam int unsigned SYS_ARCH_W    = 5;

  typedef struct packed {
    logic                  valid;
    logic                  has_dest;
    logic [SYS_ARCH_W-1:0] dest_arch;
    logic [SYS_PREG_W-1:0] tag;
    logic [SYS_PREG_W-1:0] told;
  } ROB_DISPATCH_INPACKET;

  typedef struct packed {
    logic                     valid;
    logic [SYS_ROB_IDX_W-1:0] rob_idx;
    logic                     mispredict;
  } ROB_COMPLETE_INPACKET;

  typedef struct packed {
    logic                  valid;
    logic                  completed;
    logic                  mispredict;
    logic                  has_dest;
    logic [SYS_ARCH_W-1:0] dest_arch;
    logic [SYS_PREG_W-1:0] tag;
    logic [SYS_PREG_W-1:0] told;
  } ROB_ENTRY;

  typedef struct packed {
    logic                  write_en;
    logic [SYS_ARCH_W-1:0] addr;
    logic [SYS_PREG_W-1:0] tag;
  } RRAT_WRITE_INPACKET;

  typedef struct packed {
    logic                  valid;
    logic [SYS_PREG_W-1:0] told;
  } FREELIST_RELEASE_PACKET;

endpackage

// File: rtl/rob_retire_sel.sv
// In-order retire selection over the SCALAR entries starting at head; a retiring
// mispredict ends the retire group and raises rollback.
module rob_retire_sel
  import sys_defs::*;
#(
  parameter int unsigned SCALAR = 2
) (
  input  ROB_ENTRY               [SCALAR-1:0] window_i,
  output logic                   [SCALAR-1:0] retire_mask_o,
  output RRAT_WRITE_INPACKET     [SCALAR-1:0] rrat_write_o,
  output FREELIST_RELEASE_PACKET [SCALAR-1:0] release_o,
  output logic                                rollback_o,
  output logic [$clog2(SCALAR):0]             retire_count_o
);

  localparam int unsigned CNT_W = $clog2(SCALAR) + 1;

  logic chain;

  always_comb begin
    chain          = 1'b1;
    retire_mask_o  = '0;
    rrat_write_o   = '0;
    release_o      = '0;
    rollback_o     = 1'b0;
    retire_count_o = '0;
    for (int unsigned k = 0; k < SCALAR; k++) begin
      if (chain && window_i[k].valid && window_i[k].completed) begin
        retire_mask_o[k]         = 1'b1;
        retire_count_o           = CNT_W'(k + 1);
        rrat_write_o[k].write_en = window_i[k].has_dest;
        rrat_write_o[k].addr     = window_i[k].dest_arch;
        rrat_write_o[k].tag      = window_i[k].tag;
        release_o[k].valid       = window_i[k].has_dest;
        release_o[k].told        = window_i[k].told;
        if (window_i[k].mispredict) begin
          rollback_o = 1'b1;
          chain      = 1'b0;
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob.sv
// Reorder buffer: circular entry store with wrap-bit head/tail pointers,
// SCALAR-wide dispatch, completion and in-order retire with mispredict rollback.
module rob
  import sys_defs::*;
#(
  parameter int unsigned SCALAR         = 2,
  parameter int unsigned ROB_DEPTH      = 16,
  parameter int unsigned PREG_IDX_WIDTH = 6,
  parameter int unsigned ARCH_IDX_WIDTH = 5
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  ROB_DISPATCH_INPACKET   [SCALAR-1:0]              rob_dispatch_packet,
  input  ROB_COMPLETE_INPACKET   [SCALAR-1:0]              rob_complete_packet,
  output logic                                             dispatch_stall,
  output logic                   [SCALAR-1:0][$clog2(ROB_DEPTH)-1:0] dispatch_rob_idx,
  output RRAT_WRITE_INPACKET     [SCALAR-1:0]              rrat_write_packet,
  output FREELIST_RELEASE_PACKET [SCALAR-1:0]              freelist_release,
  output logic                                             rollback_en,
  output logic                   [$clog2(SCALAR):0]        retire_count
);

  localparam int unsigned IDX_W = $clog2(ROB_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(SCALAR) + 1;

  // Packet field widths come from sys_defs, so the overrides must agree with it.
  if (PREG_IDX_WIDTH != SYS_PREG_W || ARCH_IDX_WIDTH != SYS_ARCH_W ||
      ROB_DEPTH != SYS_ROB_DEPTH) begin : g_width_check
    $error("rob parameters disagree with sys_defs widths");
  end

  logic     [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic     [PTR_W-1:0]     occupancy, free_slots;
  ROB_ENTRY [ROB_DEPTH-1:0] entries_q, entries_d;
  ROB_ENTRY [SCALAR-1:0]    window;
  logic     [SCALAR-1:0]    retire_mask;
  logic     [IDX_W-1:0]     rd_idx, wr_idx;
  logic     [CNT_W-1:0]     disp_count;
  logic                     accept;

  assign occupancy      = tail_q - head_q;
  assign free_slots     = PTR_W'(ROB_DEPTH) - occupancy;
  assign dispatch_stall = free_slots < PTR_W'(SCALAR);

  always_comb begin
    rd_idx           = '0;
    window           = '0;
    dispatch_rob_idx = '0;
    for (int unsigned k = 0; k < SCALAR; k++) begin
      dispatch_rob_idx[k] = tail_q[IDX_W-1:0] + IDX_W'(k);
      rd_idx              = head_q[IDX_W-1:0] + IDX_W'(k);
      window[k]           = entries_q[rd_idx];
    end
  end

  rob_retire_sel #(
    .SCALAR(SCALAR)
  ) u_retire_sel (
    .window_i      (window),
    .retire_mask_o (retire_mask),
    .rrat_write_o  (rrat_write_packet),
    .release_o     (freelist_release),
    .rollback_o    (rollback_en),
    .retire_count_o(retire_count)
  );

  always_comb begin
    entries_d  = entries_q;
    head_d     = head_q;
    tail_d     = tail_q;
    wr_idx     = '0;
    disp_count = '0;
    accept     = 1'b1;
    if (rollback_en) begin
      entries_d = '0;
      head_d    = head_q + PTR_W'(retire_count);
      tail_d    = head_q + PTR_W'(retire_count);
    end else begin
      for (int unsigned k = 0; k < SCALAR; k++) begin
        if (rob_complete_packet[k].valid && entries_q[rob_complete_packet[k].rob_idx].valid) begin
          entries_d[rob_complete_packet[k].rob_idx].completed  = 1'b1;
          entries_d[rob_complete_packet[k].rob_idx].mispredict = rob_complete_packet[k].mispredict;
        end
      end
      for (int unsigned k = 0; k < SCALAR; k++) begin
        if (retire_mask[k]) begin
          wr_idx            = head_q[IDX_W-1:0] + IDX_W'(k);
          entries_d[wr_idx] = '0;
        end
      end
      head_d = head_q + PTR_W'(retire_count);
      // Slots are accepted as a contiguous prefix; stall uses pre-retire occupancy.
      if (!dispatch_stall) begin
        for (int unsigned k = 0; k < SCALAR; k++) begin
          accept = accept & rob_dispatch_packet[k].valid;
          if (accept) begin
            wr_idx                      = tail_q[IDX_W-1:0] + IDX_W'(k);
            entries_d[wr_idx]           = '0;
            entries_d[wr_idx].valid     = 1'b1;
            entries_d[wr_idx].has_dest  = rob_dispatch_packet[k].has_dest;
            entries_d[wr_idx].dest_arch = rob_dispatch_packet[k].dest_arch;
            entries_d[wr_idx].tag       = rob_dispatch_packet[k].tag;
            entries_d[wr_idx].told      = rob_dispatch_packet[k].told;
            disp_count                  = CNT_W'(k + 1);
          end
        end
      end
      tail_d = tail_q + PTR_W'(disp_count);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      entries_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: a scoreboard queue of dispatched entries is popped and
// compared against the retire outputs, alongside pointer/stall checks from a small model.
module tb_rob;
  import sys_defs::*;

  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset;
  ROB_DISPATCH_INPACKET   [1:0]      dp;
  ROB_COMPLETE_INPACKET   [1:0]      cp;
  logic                              stall;
  logic                   [1:0][3:0] didx;
  RRAT_WRITE_INPACKET     [1:0]      rw;
  FREELIST_RELEASE_PACKET [1:0]      fr;
  logic                              rb;
  logic                   [1:0]      rc;

  always #5 clock = ~clock;

  rob #(
    .SCALAR(2), .ROB_DEPTH(16), .PREG_IDX_WIDTH(6), .ARCH_IDX_WIDTH(5)
  ) dut (
    .clock(clock), .reset(reset),
    .rob_dispatch_packet(dp), .rob_complete_packet(cp),
    .dispatch_stall(stall), .dispatch_rob_idx(didx),
    .rrat_write_packet(rw), .freelist_release(fr),
    .rollback_en(rb), .retire_count(rc)
  );

  typedef struct { bit hd; int arch; int tag; int told; } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int occ   = 0;
  int tail_m = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    dp = '0;
    cp = '0;
  endtask

  task automatic disp(input int slot, input bit hd, input int arch, input int tag, input int told);
    dp[slot].valid     = 1'b1;
    dp[slot].has_dest  = hd;
    dp[slot].dest_arch = 5'(arch);
    dp[slot].tag       = 6'(tag);
    dp[slot].told      = 6'(told);
  endtask

  task automatic comp(input int slot, input int idx, input bit mp);
    cp[slot].valid      = 1'b1;
    cp[slot].rob_idx    = 4'(idx);
    cp[slot].mispredict = mp;
  endtask

  // Record the first n driven dispatch slots as accepted by the model.
  task automatic accept(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.hd = dp[k].has_dest; e.arch = int'(dp[k].dest_arch);
      e.tag = int'(dp[k].tag); e.told = int'(dp[k].told);
      sb.push_back(e);
    end
    occ += n;
    tail_m = (tail_m + n) % DEPTH;
  endtask

  task automatic chk_ptr(input string tag);
    chk({tag, "_idx0"}, 64'(didx[0]), 64'(tail_m));
    chk({tag, "_idx1"}, 64'(didx[1]), 64'((tail_m + 1) % DEPTH));
    chk({tag, "_stall"}, 64'(stall), 64'((DEPTH - occ) < 2));
  endtask

  task automatic check_retire(input string tag, input int n, input bit rbx);
    exp_t e;
    chk({tag, "_count"}, 64'(rc), 64'(n));
    chk({tag, "_rollback"}, 64'(rb), 64'(rbx));
    for (int k = 0; k < 2; k++) begin
      if (k < n) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $error("FAIL %s_sb_empty observed=retire expected=none", tag);
        end else begin
          e = sb.pop_front();
          chk({tag, "_wen"},  64'(rw[k].write_en), 64'(e.hd));
          chk({tag, "_addr"}, 64'(rw[k].addr),     64'(e.arch));
          chk({tag, "_tag"},  64'(rw[k].tag),      64'(e.tag));
          chk({tag, "_relv"}, 64'(fr[k].valid),    64'(e.hd));
          chk({tag, "_told"}, 64'(fr[k].told),     64'(e.told));
        end
      end else begin
        chk({tag, "_rw_zero"}, 64'(rw[k]), 64'(0));
        chk({tag, "_fr_zero"}, 64'(fr[k]), 64'(0));
      end
    end
  endtask

  task automatic edge_step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    reset = 1'b1;
    #1;
    chk_ptr("rst");
    check_retire("rst", 0, 0);
    @(negedge clock);
    reset = 1'b0;
    edge_step();

    // Two dispatches, out-of-order completion, paired retire.
    clr(); disp(0, 1, 1, 33, 1); disp(1, 1, 2, 34, 2);
    @(negedge clock); chk_ptr("d030"); accept(2); edge_step();
    clr(); comp(0, 1, 0);
    @(negedge clock); check_retire("c_idx1", 0, 0); edge_step();
    clr(); comp(0, 0, 0);
    @(negedge clock); check_retire("c_idx0", 0, 0); edge_step();
    clr();
    @(negedge clock); check_retire("r030", 2, 0); occ -= 2; edge_step();

    // Slot 1 alone must not dispatch.
    clr(); disp(1, 1, 3, 35, 3);
    @(negedge clock); chk_ptr("s1only"); edge_step();
    clr(); disp(0, 0, 7, 40, 9);
    @(negedge clock); chk_ptr("s1ign"); accept(1); edge_step();
    clr(); comp(0, 2, 0);
    @(negedge clock); check_retire("nodst_wait", 0, 0); edge_step();
    // Completion of invalid entry 5 in the same cycle must be ignored.
    clr(); comp(0, 5, 0);
    @(negedge clock); check_retire("r034", 1, 0); occ -= 1; edge_step();

    // Fill from head=3 through the wrap point.
    for (int i = 0; i < 7; i++) begin
      clr(); disp(0, 1, i + 1, 2 * i + 1, i); disp(1, 1, i + 10, 2 * i + 2, i + 20);
      @(negedge clock); chk_ptr("fill"); accept(2); edge_step();
    end
    clr(); disp(0, 1, 30, 50, 40);
    @(negedge clock); chk_ptr("fill15"); accept(1); edge_step();
    clr(); disp(0, 1, 31, 51, 41); disp(1, 1, 31, 52, 42); comp(0, 3, 0); comp(1, 4, 0);
    @(negedge clock); chk_ptr("full"); check_retire("full", 0, 0); edge_step();
    // Retire two while stalled: dispatch still blocked by pre-retire occupancy.
    clr(); disp(0, 1, 31, 51, 41); disp(1, 1, 31, 52, 42);
    @(negedge clock); chk_ptr("ret_stall"); check_retire("ret_stall", 2, 0); occ -= 2; edge_step();
    clr(); comp(0, 5, 0); comp(1, 6, 0); disp(0, 1, 12, 53, 43);
    @(negedge clock); chk_ptr("occ13"); check_retire("stale5", 0, 0); accept(1); edge_step();
    // Retire two and dispatch two with exactly two free.
    clr(); disp(0, 1, 13, 54, 44); disp(1, 0, 14, 55, 45);
    @(negedge clock); chk_ptr("r033"); check_retire("r033", 2, 0); occ -= 2; accept(2); edge_step();
    clr();
    @(negedge clock); chk_ptr("occ_same"); check_retire("occ_same", 0, 0); edge_step();

    // Mispredicted head with completed head+1.
    clr(); comp(0, 7, 1); comp(1, 8, 0);
    @(negedge clock); check_retire("mp_wait", 0, 0); edge_step();
    clr(); disp(0, 1, 20, 60, 50); disp(1, 1, 21, 61, 51); comp(0, 9, 0);
    @(negedge clock); chk_ptr("rb_cyc"); check_retire("r032", 1, 1);
    sb.delete(); occ = 0; tail_m = 8; edge_step();
    clr();
    @(negedge clock); chk_ptr("post_rb"); check_retire("post_rb", 0, 0); edge_step();

    // Five in flight, two retirable, then reset between edges.
    clr(); disp(0, 1, 1, 11, 21); disp(1, 1, 2, 12, 22);
    @(negedge clock); accept(2); edge_step();
    clr(); disp(0, 1, 3, 13, 23); disp(1, 1, 4, 14, 24);
    @(negedge clock); accept(2); edge_step();
    clr(); disp(0, 1, 5, 15, 25); comp(0, 8, 0); comp(1, 9, 0);
    @(negedge clock); accept(1); edge_step();
    clr();
    @(negedge clock); chk_ptr("pre_rst"); check_retire("pre_rst", 2, 0);
    #2 reset = 1'b1;
    #1;
    sb.delete(); occ = 0; tail_m = 0;
    chk_ptr("mid_rst"); check_retire("mid_rst", 0, 0);
    @(negedge clock);
    reset = 1'b0;
    edge_step();
    @(negedge clock); chk_ptr("post_rst"); check_retire("post_rst", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
